// File: rtl/iiravg_mux.sv
// iiravg_mux: time-shared multi-channel exponential averager.
// One datapath computes avg += (x - avg) >>> LGALPHA for NCH channels.
// A round-robin arbiter admits at most one sample per clock.
// Stage 1 registers the granted sample.
// Stage 2 reads that channel's average, updates it and registers the
// channel-tagged result.
// Optional build macro: IIRAVG_PRELOAD_EN. When it is defined, the first
// update of a channel loads the sample directly instead of running the
// recursion.
module iiravg_mux #(
  parameter int NCH     = 4,
  parameter int LGNCH   = 2,
  parameter int IW      = 15,
  parameter int OW      = 16,
  parameter int LGALPHA = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NCH-1:0]    i_valid,
  input  logic [NCH*IW-1:0] i_data,
  output logic [NCH-1:0]    o_ready,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [LGNCH-1:0]  o_chan,
  output logic [OW-1:0]     o_data
);

  // Arithmetic right shift of an OW-bit two's-complement value by LGALPHA.
  function automatic logic [OW-1:0] asr_alpha(input logic [OW-1:0] v);
    logic signed [OW-1:0] s;
    s = $signed(v);
    asr_alpha = s >>> LGALPHA;
  endfunction

  // Left-align an IW-bit sample into the OW-bit average domain.
  function automatic logic [OW-1:0] align_sample(input logic [IW-1:0] d);
    align_sample = OW'(d) << (OW - IW);
  endfunction

  // Round-robin pointer: the first channel considered on the next search.
  logic [LGNCH-1:0] r_rr;

  // Arbiter results.
  logic             w_grant_found;
  logic [LGNCH-1:0] w_grant_idx;
  logic [IW-1:0]    w_grant_data;
  logic             w_accept;
  logic [LGNCH-1:0] w_rr_next;

  // Stage 1 registers.
  logic             r_s1_valid;
  logic [LGNCH-1:0] r_s1_chan;
  logic [IW-1:0]    r_s1_data;

  // Per-channel average register file.
  logic [OW-1:0]    r_avg [NCH];

  // Stage 2 datapath.
  logic [OW-1:0]    w_avg_cur;
  logic [OW-1:0]    w_x;
  logic [OW-1:0]    w_diff;
  logic [OW-1:0]    w_adj;
  logic [OW-1:0]    w_avg_new;

`ifdef IIRAVG_PRELOAD_EN
  // A channel is primed once its first sample has loaded the average.
  logic [NCH-1:0]   r_primed;
`endif

  // Search upward from the pointer, modulo NCH, for the first requester.
  // Only indices below NCH are ever visited.
  always_comb begin : arb_search
    logic             found;
    logic [LGNCH-1:0] idx;
    logic [IW-1:0]    dat;
    int               k;
    found = 1'b0;
    idx   = '0;
    dat   = '0;
    k     = 0;
    for (int i = 0; i < NCH; i++) begin
      k = (int'(r_rr) + i) % NCH;
      if (!found && i_valid[k]) begin
        found = 1'b1;
        idx   = k[LGNCH-1:0];
        dat   = i_data[k*IW +: IW];
      end else begin
        found = found;
      end
    end
    w_grant_found = found;
    w_grant_idx   = idx;
    w_grant_data  = dat;
  end

  // Ready is one-hot on the granted channel.
  // It is held low during reset and flush cycles.
  always_comb begin
    o_ready = '0;
    if (w_grant_found && !i_reset && !i_flush) begin
      o_ready[w_grant_idx] = 1'b1;
    end else begin
      o_ready = '0;
    end
  end

  assign w_accept = |(o_ready & i_valid);

  // Pointer successor: the channel after the grant, wrapping at NCH.
  always_comb begin
    w_rr_next = '0;
    if (w_grant_idx == LGNCH'(NCH - 1)) begin
      w_rr_next = '0;
    end else begin
      w_rr_next = w_grant_idx + LGNCH'(1);
    end
  end

  // The pointer advances past each accepted channel.
  // Flush leaves the pointer where it is.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr <= '0;
    end else if (w_accept) begin
      r_rr <= w_rr_next;
    end else begin
      r_rr <= r_rr;
    end
  end

  // Stage 1 captures the accepted sample and its channel.
  // Reset and flush both discard it.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_s1_valid <= 1'b0;
      r_s1_chan  <= '0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_chan <= w_grant_idx;
        r_s1_data <= w_grant_data;
      end else begin
        r_s1_chan <= r_s1_chan;
        r_s1_data <= r_s1_data;
      end
    end
  end

  // Stage 2 reads the register file combinationally.
  // A back-to-back sample on the same channel therefore sees the average
  // that was just written.
  always_comb begin
    w_avg_cur = r_avg[r_s1_chan];
    w_x       = align_sample(r_s1_data);
    w_diff    = w_x - w_avg_cur;
    w_adj     = asr_alpha(w_diff);
`ifdef IIRAVG_PRELOAD_EN
    if (r_primed[r_s1_chan]) begin
      w_avg_new = w_avg_cur + w_adj;
    end else begin
      w_avg_new = w_x;
    end
`else
    w_avg_new = w_avg_cur + w_adj;
`endif
  end

  // Write the updated average back to its channel.
  // Reset and flush clear every channel.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      for (int c = 0; c < NCH; c++) begin
        r_avg[c] <= '0;
      end
    end else if (r_s1_valid) begin
      r_avg[r_s1_chan] <= w_avg_new;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        r_avg[c] <= r_avg[c];
      end
    end
  end

`ifdef IIRAVG_PRELOAD_EN
  // Mark a channel primed after its first update.
  // Reset and flush clear all primed bits.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_primed <= '0;
    end else if (r_s1_valid) begin
      r_primed[r_s1_chan] <= 1'b1;
    end else begin
      r_primed <= r_primed;
    end
  end
`endif

  // Registered output.
  // o_valid pulses once per update; channel and data hold until the next
  // update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_chan  <= '0;
      o_data  <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_chan  <= o_chan;
      o_data  <= o_data;
    end else begin
      o_valid <= r_s1_valid;
      if (r_s1_valid) begin
        o_chan <= r_s1_chan;
        o_data <= w_avg_new;
      end else begin
        o_chan <= o_chan;
        o_data <= o_data;
      end
    end
  end

endmodule

// File: tb/tb_iiravg_mux.sv
// Self-checking bench for iiravg_mux.
// The reference model keeps one average per channel and a round-robin
// index. It applies the recursion with integer arithmetic at accept time
// and then delays the result to the output.
module tb_iiravg_mux;
  localparam int NCH = 4, LGNCH = 2, IW = 15, OW = 16, LGALPHA = 4;

  logic              clk;
  logic              i_reset, i_flush;
  logic [NCH-1:0]    i_valid;
  logic [NCH*IW-1:0] i_data;
  logic [NCH-1:0]    o_ready;
  logic              o_valid;
  logic [LGNCH-1:0]  o_chan;
  logic [OW-1:0]     o_data;

  iiravg_mux #(.NCH(NCH), .LGNCH(LGNCH), .IW(IW), .OW(OW), .LGALPHA(LGALPHA)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .i_flush(i_flush), .o_valid(o_valid),
    .o_chan(o_chan), .o_data(o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state.
  int  m_rr;
  int  m_avg    [NCH];
  bit  m_primed [NCH];
  bit  m_s1v;
  int  m_s1c, m_s1d;
  bit  m_ev;
  int  m_ec, m_ed;

  // DUT outputs captured at the most recent negative edge.
  logic [NCH-1:0]   last_ready;
  logic             last_valid;
  logic [LGNCH-1:0] last_chan;
  logic [OW-1:0]    last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Averager rule in plain integers.
  // The difference wraps to OW bits and is read as signed.
  // The shift is a floor division by 2**LGALPHA.
  // The new average wraps to OW bits.
  function automatic int iir(input int avg, input int s, input bit primed);
    int x, d, adj;
    x = s * (1 << (OW - IW));
`ifdef IIRAVG_PRELOAD_EN
    if (!primed) return x;
`endif
    d = (x - avg) & ((1 << OW) - 1);
    if (d >= (1 << (OW - 1))) d = d - (1 << OW);
    if (d >= 0) adj = d / (1 << LGALPHA);
    else adj = -((-d + (1 << LGALPHA) - 1) / (1 << LGALPHA));
    return (avg + adj) & ((1 << OW) - 1);
  endfunction

  task automatic model_reset();
    m_rr = 0;
    m_s1v = 0; m_s1c = 0; m_s1d = 0;
    m_ev = 0; m_ec = 0; m_ed = 0;
    for (int c = 0; c < NCH; c++) begin m_avg[c] = 0; m_primed[c] = 0; end
  endtask

  // One clock.
  // Drive the inputs, check every output at the negative edge, then advance
  // the model on the positive edge.
  task automatic cycle(input logic [NCH-1:0] v, input logic [NCH*IW-1:0] d,
                       input bit fl, input bit rs);
    int g;
    logic [NCH-1:0] exp_ready;
    i_valid = v; i_data = d; i_flush = fl; i_reset = rs;
    @(negedge clk);
    g = -1;
    if (!rs && !fl) begin
      for (int i = 0; i < NCH; i++) begin
        int k;
        k = (m_rr + i) % NCH;
        if (g < 0 && v[k]) g = k;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("o_ready", 32'(o_ready), 32'(exp_ready));
    chk("o_valid", 32'(o_valid), 32'(m_ev));
    chk("o_chan",  32'(o_chan),  32'(m_ec));
    chk("o_data",  32'(o_data),  32'(m_ed));
    last_ready = o_ready; last_valid = o_valid; last_chan = o_chan; last_data = o_data;
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else if (fl) begin
      for (int c = 0; c < NCH; c++) begin m_avg[c] = 0; m_primed[c] = 0; end
      m_s1v = 0; m_ev = 0;
    end else begin
      m_ev = m_s1v;
      if (m_s1v) begin m_ec = m_s1c; m_ed = m_s1d; end
      m_s1v = (g >= 0);
      if (g >= 0) begin
        m_s1c = g;
        m_s1d = iir(m_avg[g], int'(d[g*IW +: IW]), m_primed[g]);
        m_avg[g] = m_s1d;
        m_primed[g] = 1;
        m_rr = (g + 1) % NCH;
      end
    end
    #1;
  endtask

  logic [NCH*IW-1:0] dat;
  logic [NCH*IW-1:0] ch0_1000;
  logic [NCH*IW-1:0] ch2_1000;

  initial begin
    ch0_1000 = (NCH*IW)'(15'h1000);
    ch2_1000 = (NCH*IW)'(15'h1000) << (2*IW);
    // Unchecked power-up reset; all checking starts from a known state.
    i_reset = 1'b1; i_flush = 1'b0; i_valid = '0; i_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle(4'b0000, '0, 1'b0, 1'b1);
    chk("reset_ready", 32'(last_ready), 32'h0);
    chk("reset_valid", 32'(last_valid), 32'h0);

    // Single channel: 0x1000 held on channel 0.
    cycle(4'b0001, ch0_1000, 1'b0, 1'b0);
    cycle(4'b0001, ch0_1000, 1'b0, 1'b0);
    cycle(4'b0001, ch0_1000, 1'b0, 1'b0);
`ifdef IIRAVG_PRELOAD_EN
    chk("single_1", 32'(last_data), 32'h2000);
`else
    chk("single_1", 32'(last_data), 32'h0200);
`endif
    chk("single_1_valid", 32'(last_valid), 32'h1);
    cycle(4'b0001, ch0_1000, 1'b0, 1'b0);
`ifdef IIRAVG_PRELOAD_EN
    chk("single_2", 32'(last_data), 32'h2000);
`else
    chk("single_2", 32'(last_data), 32'h03E0);
`endif
    cycle(4'b0000, '0, 1'b0, 1'b0);
`ifdef IIRAVG_PRELOAD_EN
    chk("single_3", 32'(last_data), 32'h2000);
`else
    chk("single_3", 32'(last_data), 32'h05A2);
`endif
    cycle(4'b0000, '0, 1'b0, 1'b1);

    // All four channels request continuously.
    dat = {15'h0400, 15'h0300, 15'h0200, 15'h0100};
    cycle(4'b1111, dat, 1'b0, 1'b0); chk("rr_0", 32'(last_ready), 32'h1);
    cycle(4'b1111, dat, 1'b0, 1'b0); chk("rr_1", 32'(last_ready), 32'h2);
    for (int k = 0; k < 4; k++) begin
      cycle(4'b1111, dat, 1'b0, 1'b0);
      if (k < 2) chk("rr_seq", 32'(last_ready), 32'(4 << k));
      else chk("rr_wrap", 32'(last_ready), 32'(1 << (k - 2)));
      chk("all_chan", 32'(last_chan), 32'(k));
`ifdef IIRAVG_PRELOAD_EN
      chk("all_first", 32'(last_data), 32'(16'h0200 * (k + 1)));
`else
      chk("all_first", 32'(last_data), 32'(16'h0020 * (k + 1)));
`endif
    end
    cycle(4'b0000, '0, 1'b0, 1'b1);

    // Sparse requests 1010 from pointer 0.
    cycle(4'b1010, {4{15'h1234}}, 1'b0, 1'b0); chk("sparse_1", 32'(last_ready), 32'h2);
    cycle(4'b1010, {4{15'h1234}}, 1'b0, 1'b0); chk("sparse_3", 32'(last_ready), 32'h8);
    cycle(4'b1010, {4{15'h1234}}, 1'b0, 1'b0); chk("sparse_1b", 32'(last_ready), 32'h2);
    cycle(4'b0000, '0, 1'b0, 1'b1);

    // Negative step on channel 2.
    cycle(4'b0100, ch2_1000, 1'b0, 1'b0);
    cycle(4'b0100, '0, 1'b0, 1'b0);
    cycle(4'b0000, '0, 1'b0, 1'b0);
    cycle(4'b0000, '0, 1'b0, 1'b0);
    chk("neg_chan", 32'(last_chan), 32'h2);
`ifdef IIRAVG_PRELOAD_EN
    chk("neg_step", 32'(last_data), 32'h1E00);
`else
    chk("neg_step", 32'(last_data), 32'h01E0);
`endif

    // Flush after ten samples on channel 0, then one fresh sample.
    repeat (10) cycle(4'b0001, ch0_1000, 1'b0, 1'b0);
    cycle(4'b0001, ch0_1000, 1'b1, 1'b0);
    chk("flush_ready", 32'(last_ready), 32'h0);
    cycle(4'b0001, ch0_1000, 1'b0, 1'b0);
    chk("flush_drop", 32'(last_valid), 32'h0);
    cycle(4'b0000, '0, 1'b0, 1'b0);
    cycle(4'b0000, '0, 1'b0, 1'b0);
    chk("flush_restart_valid", 32'(last_valid), 32'h1);
`ifdef IIRAVG_PRELOAD_EN
    chk("flush_restart", 32'(last_data), 32'h2000);
`else
    chk("flush_restart", 32'(last_data), 32'h0200);
`endif

    // Reset one cycle after an accept discards the in-flight sample.
    cycle(4'b0001, ch0_1000, 1'b0, 1'b0);
    cycle(4'b0000, '0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000, '0, 1'b0, 1'b0);
      chk("rst_no_valid", 32'(last_valid), 32'h0);
      chk("rst_data", 32'(last_data), 32'h0);
    end
    cycle(4'b1111, dat, 1'b0, 1'b0);
    chk("rst_ptr", 32'(last_ready), 32'h1);

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      dat = {$urandom, $urandom};
      cycle(4'($urandom_range(0, 15)), dat,
            ($urandom_range(0, 40) == 0), ($urandom_range(0, 90) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
